// File: rtl/div_unit.sv
// Multi-cycle signed 32-bit divider: 32 restoring steps on magnitudes, then a sign-fix cycle.
// hi holds the remainder and lo the quotient of the last completed division.
`timescale 1ns/1ps
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  div_ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  div_status
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    localparam logic [1:0] CtrlStart = 2'b01;
    localparam logic [1:0] CtrlAbort = 2'b11;

    state_e      state;
    logic [4:0]  count;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        neg_quo;
    logic        neg_rem;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [33:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Unsigned negation maps 0x80000000 onto itself, which is exactly 2^31.
    assign abs_a = a[31] ? (32'd0 - a) : a;
    assign abs_b = b[31] ? (32'd0 - b) : b;

    // Trial subtraction on the left-shifted remainder; bit 33 set means it went negative.
    assign trial   = {rem, quo[31]} - {2'b00, dvs};
    assign quo_fix = neg_quo ? (32'd0 - quo) : quo;
    assign rem_fix = neg_rem ? (32'd0 - rem[31:0]) : rem[31:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            count      <= 5'd0;
            rem        <= 33'd0;
            quo        <= 32'd0;
            dvs        <= 32'd0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            div_status <= 2'b00;
        end else begin
            unique case (state)
                StIdle: begin
                    div_status <= 2'b00;
                    if (div_ctrl == CtrlStart) begin
                        rem     <= 33'd0;
                        quo     <= abs_a;
                        dvs     <= abs_b;
                        neg_rem <= a[31];
                        neg_quo <= a[31] ^ b[31];
                        count   <= 5'd0;
                        if (b == 32'd0) begin
                            state      <= StDone;
                            div_status <= 2'b11;
                        end else begin
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (div_ctrl == CtrlAbort) begin
                        state <= StIdle;
                        count <= 5'd0;
                    end else begin
                        if (!trial[33]) begin
                            rem <= trial[32:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= {rem[31:0], quo[31]};
                            quo <= {quo[30:0], 1'b0};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state <= StFix;
                        end
                    end
                end
                StFix: begin
                    count <= 5'd0;
                    if (div_ctrl == CtrlAbort) begin
                        state <= StIdle;
                    end else begin
                        hi         <= rem_fix;
                        lo         <= quo_fix;
                        state      <= StDone;
                        div_status <= 2'b01;
                    end
                end
                StDone: begin
                    state      <= StIdle;
                    div_status <= 2'b00;
                end
                default: begin
                    state      <= StIdle;
                    div_status <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: signed results, latency, div-by-zero,
// overflow, ignored restarts, abort and asynchronous reset.
`timescale 1ns/1ps
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  div_ctrl = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  div_status;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clock      (clock),
        .reset      (reset),
        .div_ctrl   (div_ctrl),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .div_status (div_status)
    );

    always #5 clock = ~clock;

    // Presents a start for one rising edge (E0); returns at the falling edge after E0.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clock);
        div_ctrl = 2'b01;
        a        = av;
        b        = bv;
        @(negedge clock);
        div_ctrl = 2'b00;
        a        = 32'd0;
        b        = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'd0); end
        checks++; if (div_status !== 2'b00) begin errors++; $display("FAIL reset_status got %b want 00", div_status); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        start_op(32'd100, 32'd7);
        repeat (32) @(negedge clock);
        checks++; if (div_status !== 2'b00) begin errors++; $display("FAIL basic_early_status got %b want 00", div_status); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL basic_early_lo got %h want %h", lo, 32'd0); end
        @(negedge clock);
        checks++; if (div_status !== 2'b01) begin errors++; $display("FAIL basic_status got %b want 01", div_status); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo got %h want %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL basic_hi got %h want %h", hi, 32'd2); end
        @(negedge clock);
        checks++; if (div_status !== 2'b00) begin errors++; $display("FAIL basic_status_after got %b want 00", div_status); end
    endtask

    task automatic test_signed();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vlo [3];
        logic [31:0] vhi [3];
        va[0] = 32'hFFFFFF9C; vb[0] = 32'd7;        vlo[0] = 32'hFFFFFFF2; vhi[0] = 32'hFFFFFFFE;
        va[1] = 32'd100;      vb[1] = 32'hFFFFFFF9; vlo[1] = 32'hFFFFFFF2; vhi[1] = 32'd2;
        va[2] = 32'hFFFFFF9C; vb[2] = 32'hFFFFFFF9; vlo[2] = 32'd14;       vhi[2] = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i]);
            repeat (33) @(negedge clock);
            checks++; if (div_status !== 2'b01) begin errors++; $display("FAIL signed%0d_status got %b want 01", i, div_status); end
            checks++; if (lo !== vlo[i]) begin errors++; $display("FAIL signed%0d_lo got %h want %h", i, lo, vlo[i]); end
            checks++; if (hi !== vhi[i]) begin errors++; $display("FAIL signed%0d_hi got %h want %h", i, hi, vhi[i]); end
            @(negedge clock);
        end
    endtask

    task automatic test_overflow();
        start_op(32'h80000000, 32'hFFFFFFFF);
        repeat (33) @(negedge clock);
        checks++; if (div_status !== 2'b01) begin errors++; $display("FAIL ovf_status got %b want 01", div_status); end
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo got %h want %h", lo, 32'h80000000); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ovf_hi got %h want %h", hi, 32'd0); end
        @(negedge clock);
    endtask

    task automatic test_ignore_start();
        start_op(32'd100, 32'd7);
        div_ctrl = 2'b01;
        a        = 32'd1;
        b        = 32'd1;
        repeat (20) @(negedge clock);
        div_ctrl = 2'b00;
        repeat (13) @(negedge clock);
        checks++; if (div_status !== 2'b01) begin errors++; $display("FAIL ignore_status got %b want 01", div_status); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ignore_lo got %h want %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL ignore_hi got %h want %h", hi, 32'd2); end
        @(negedge clock);
    endtask

    task automatic test_div_zero();
        start_op(32'd5, 32'd0);
        checks++; if (div_status !== 2'b11) begin errors++; $display("FAIL dz_status got %b want 11", div_status); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL dz_hi got %h want %h", hi, 32'd2); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL dz_lo got %h want %h", lo, 32'd14); end
        @(negedge clock);
        checks++; if (div_status !== 2'b00) begin errors++; $display("FAIL dz_status_after got %b want 00", div_status); end
    endtask

    task automatic test_abort();
        int pulses = 0;
        start_op(32'd50, 32'd5);
        repeat (5) @(negedge clock);
        div_ctrl = 2'b11;
        @(negedge clock);
        div_ctrl = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (div_status !== 2'b00) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL abort_hi got %h want %h", hi, 32'd2); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL abort_lo got %h want %h", lo, 32'd14); end
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        start_op(32'd100, 32'd7);
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_hi got %h want %h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_lo got %h want %h", lo, 32'd0); end
        checks++; if (div_status !== 2'b00) begin errors++; $display("FAIL rst_status got %b want 00", div_status); end
        // Release reset and start on the very next rising edge.
        @(negedge clock);
        reset    = 1'b1;
        div_ctrl = 2'b01;
        a        = 32'd9;
        b        = 32'd3;
        @(negedge clock);
        div_ctrl = 2'b00;
        a        = 32'd0;
        b        = 32'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (div_status !== 2'b00) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_pulses got %0d want 0", pulses); end
        @(negedge clock);
        checks++; if (div_status !== 2'b01) begin errors++; $display("FAIL rst_new_status got %b want 01", div_status); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL rst_new_lo got %h want %h", lo, 32'd3); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_new_hi got %h want %h", hi, 32'd0); end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_ignore_start();
        test_div_zero();
        test_abort();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
